// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: word/address widths,
// the fetch FSM encoding and the {pc, inst} entry held in the queue.
package inst_fetch_queue_pkg;

   localparam int INST_SIZE = 32;
   localparam int ADDR_SIZE = 32;

   typedef logic [INST_SIZE-1:0] inst_t;
   typedef logic [ADDR_SIZE-1:0] addr_t;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_WAIT = 2'd1,
      IF_DROP = 2'd2
   } if_state_e;

   typedef struct packed {
      addr_t pc;
      inst_t inst;
   } iq_entry_t;

   localparam int ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Circular FIFO for fetched {pc, inst} entries. Head entry is read
// combinationally; flush empties the queue and overrides push/pop.
module iq_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head_reg;
   logic [PW-1:0]    tail_reg;
   logic [PW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_CNT);
   assign do_pop  = pop && !empty && !flush;
   // A pop in the same cycle frees the slot, so push at full is accepted then.
   assign do_push = push && !flush && (!full || do_pop);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (do_push) tail_reg <= tail_reg + PW'(1);
         if (do_pop)  head_reg <= head_reg + PW'(1);
         count_reg <= count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[tail_reg] <= push_data;
   end

   assign head_data = mem[head_reg];
   assign count     = count_reg;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues one sequential fetch at a time, buffers
// returned words with their PCs and presents the oldest entry to decode.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int    IQ_DEPTH = 16,
   parameter addr_t RESET_PC = 32'h0
) (
   input  logic  clk_in,
   input  logic  rst_in,
   input  logic  rdy_in,
   input  logic  clear,
   input  addr_t clear_pc,
   output logic  mem_req,
   output addr_t mem_addr,
   input  logic  mem_valid,
   input  inst_t mem_data,
   input  logic  Get_Inst,
   output inst_t Inst_out,
   output addr_t pc_out,
   output logic  en_out,
   output logic  IQ_isempty
);

   localparam int CW = $clog2(IQ_DEPTH) + 1;

   if_state_e state_reg, state_next;
   addr_t     pc_reg, pc_next;
   addr_t     mem_addr_reg, mem_addr_next;
   logic      mem_req_reg, mem_req_next;
   logic      push;
   logic      fifo_pop;
   logic      fifo_flush;
   iq_entry_t fifo_push_data;
   iq_entry_t fifo_head;
   logic [CW-1:0] fifo_count;
   logic      fifo_empty;
   logic      fifo_full;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg    <= IF_IDLE;
         pc_reg       <= RESET_PC;
         mem_req_reg  <= 1'b0;
         mem_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         mem_req_reg  <= mem_req_next;
         mem_addr_reg <= mem_addr_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      mem_req_next  = mem_req_reg;
      mem_addr_next = mem_addr_reg;
      push          = 1'b0;
      if (rdy_in) begin
         if (clear) begin
            pc_next      = clear_pc;
            mem_req_next = 1'b0;
            // An outstanding request still owes one response; DROP swallows it.
            state_next   = (state_reg == IF_IDLE || mem_valid) ? IF_IDLE : IF_DROP;
         end else begin
            case (state_reg)
               IF_IDLE: begin
                  if (!fifo_full) begin
                     mem_req_next  = 1'b1;
                     mem_addr_next = pc_reg;
                     state_next    = IF_WAIT;
                  end
               end
               IF_WAIT: begin
                  if (mem_valid) begin
                     push         = 1'b1;
                     pc_next      = pc_reg + 32'd4;
                     mem_req_next = 1'b0;
                     state_next   = IF_IDLE;
                  end
               end
               IF_DROP: begin
                  if (mem_valid) state_next = IF_IDLE;
               end
               default: state_next = IF_IDLE;
            endcase
         end
      end
   end

   assign fifo_pop       = rdy_in && !clear && Get_Inst;
   assign fifo_flush     = rdy_in && clear;
   assign fifo_push_data = '{pc: pc_reg, inst: mem_data};

   iq_fifo #(
      .DEPTH (IQ_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head_data (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign mem_req    = mem_req_reg;
   assign mem_addr   = mem_addr_reg;
   assign Inst_out   = fifo_head.inst;
   assign pc_out     = fifo_head.pc;
   assign en_out     = (fifo_count != '0);
   assign IQ_isempty = fifo_empty;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: fixed vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_inst_fetch_queue;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      logic        get;
      logic        mv;
      logic [31:0] data;
      logic        req;
      logic [31:0] addr;
      logic        empty;
      logic [31:0] pc;
      logic [31:0] inst;
   } vec_t;

   logic        clk_in    = 1'b0;
   logic        rst_in    = 1'b1;
   logic        rdy_in    = 1'b1;
   logic        clear     = 1'b0;
   logic [31:0] clear_pc  = 32'h0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_data  = 32'h0;
   logic        Get_Inst  = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] Inst_out;
   logic [31:0] pc_out;
   logic        en_out;
   logic        IQ_isempty;

   // reference model: contents as a queue, fetch PC, outstanding-request bookkeeping
   ent_t        q[$];
   logic [31:0] m_pc;
   bit          pending;
   bit          stale;
   bit          exp_req;
   int          lat_cnt;
   int          lat_lo;
   int          lat_hi;
   int          n_push;
   int          checks;
   int          errors;
   vec_t        vecs[12];

   inst_fetch_queue #(
      .IQ_DEPTH (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .clear      (clear),
      .clear_pc   (clear_pc),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data),
      .Get_Inst   (Get_Inst),
      .Inst_out   (Inst_out),
      .pc_out     (pc_out),
      .en_out     (en_out),
      .IQ_isempty (IQ_isempty)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic get, input logic mv, input logic [31:0] data,
                               input logic req, input logic [31:0] addr, input logic empty,
                               input logic [31:0] pc, input logic [31:0] inst);
      vec_t v;
      v.get = get; v.mv = mv; v.data = data; v.req = req;
      v.addr = addr; v.empty = empty; v.pc = pc; v.inst = inst;
      return v;
   endfunction

   task automatic check_outputs();
      chk1("empty", IQ_isempty, q.size() == 0);
      chk1("en_out", en_out, q.size() != 0);
      chk1("mem_req", mem_req, exp_req);
      if (exp_req) chk32("mem_addr", mem_addr, m_pc);
      if (q.size() != 0) begin
         chk32("pc_out", pc_out, q[0].pc);
         chk32("inst_out", Inst_out, q[0].inst);
      end
   endtask

   // One clock: memory responder drives mem_valid, model advances, outputs compared.
   task automatic cycle();
      bit fired;
      bit pend_pre;
      bit new_req;
      int sz_pre;
      fired     = rdy_in && pending && (lat_cnt == 0);
      mem_valid = fired;
      mem_data  = fired ? $urandom() : 32'h0;
      pend_pre  = pending;
      sz_pre    = q.size();
      new_req   = 1'b0;
      @(posedge clk_in);
      if (rdy_in) begin
         if (pend_pre && !fired && lat_cnt > 0) lat_cnt--;
         if (clear) begin
            q.delete();
            m_pc    = clear_pc;
            exp_req = 1'b0;
            if (fired) begin
               pending = 1'b0;
               stale   = 1'b0;
            end else if (pend_pre) begin
               stale = 1'b1;
            end
         end else begin
            if (Get_Inst && q.size() != 0) void'(q.pop_front());
            if (fired) begin
               if (!stale) begin
                  q.push_back(ent_t'{m_pc, mem_data});
                  m_pc = m_pc + 32'd4;
                  n_push++;
               end
               pending = 1'b0;
               stale   = 1'b0;
               exp_req = 1'b0;
            end else if (!pend_pre && sz_pre < DEPTH) begin
               exp_req = 1'b1;
               new_req = 1'b1;
            end
         end
      end
      #1;
      mem_valid = 1'b0;
      if (new_req) begin
         pending = 1'b1;
         stale   = 1'b0;
         lat_cnt = int'($urandom_range(lat_hi, lat_lo));
      end
      check_outputs();
   endtask

   task automatic do_reset();
      rst_in    = 1'b0;
      mem_valid = 1'b0;
      clear     = 1'b0;
      Get_Inst  = 1'b0;
      rdy_in    = 1'b1;
      #1;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_empty", IQ_isempty, 1'b1);
      chk1("rst_en_out", en_out, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      q.delete();
      m_pc = 32'h0; pending = 1'b0; stale = 1'b0; exp_req = 1'b0;
      lat_cnt = 0; n_push = 0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
   endtask

   task automatic run_until_req(input int max);
      int n = 0;
      while (!(pending && !stale) && n < max) begin
         cycle();
         n++;
      end
      chk1("req_timeout", pending && !stale, 1'b1);
   endtask

   initial begin
      logic        snap_req;
      logic [31:0] snap_addr;
      logic        snap_empty;
      logic [31:0] snap_pc;
      int          n;
      checks = 0;
      errors = 0;
      lat_lo = 1;
      lat_hi = 1;

      // memory answers 32'h13 two cycles after each request; pops at count 1 with push
      vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'd0,  1'b1, 32'd0,  32'h0);
      vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'd0,  1'b1, 32'd0,  32'h0);
      vecs[2]  = mk(1'b0, 1'b1, 32'h13, 1'b0, 32'd0,  1'b0, 32'd0,  32'h13);
      vecs[3]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'd4,  1'b0, 32'd0,  32'h13);
      vecs[4]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'd4,  1'b0, 32'd0,  32'h13);
      vecs[5]  = mk(1'b0, 1'b1, 32'h13, 1'b0, 32'd4,  1'b0, 32'd0,  32'h13);
      vecs[6]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'd8,  1'b0, 32'd0,  32'h13);
      vecs[7]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'd8,  1'b0, 32'd4,  32'h13);
      vecs[8]  = mk(1'b1, 1'b1, 32'h17, 1'b0, 32'd8,  1'b0, 32'd8,  32'h17);
      vecs[9]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'd12, 1'b1, 32'd0,  32'h0);
      vecs[10] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'd12, 1'b1, 32'd0,  32'h0);
      vecs[11] = mk(1'b0, 1'b1, 32'h33, 1'b0, 32'd12, 1'b0, 32'd12, 32'h33);

      #2;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         Get_Inst  = vecs[i].get;
         mem_valid = vecs[i].mv;
         mem_data  = vecs[i].data;
         @(posedge clk_in);
         #1;
         $display("vec %0d: get=%b mv=%b -> req=%b addr=%h empty=%b pc=%h inst=%h",
                  i, vecs[i].get, vecs[i].mv, mem_req, mem_addr, IQ_isempty, pc_out, Inst_out);
         chk1($sformatf("vec%0d_req", i), mem_req, vecs[i].req);
         chk32($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
         chk1($sformatf("vec%0d_empty", i), IQ_isempty, vecs[i].empty);
         chk1($sformatf("vec%0d_en", i), en_out, !vecs[i].empty);
         if (!vecs[i].empty) begin
            chk32($sformatf("vec%0d_pc", i), pc_out, vecs[i].pc);
            chk32($sformatf("vec%0d_inst", i), Inst_out, vecs[i].inst);
         end
      end
      mem_valid = 1'b0;
      Get_Inst  = 1'b0;

      // fill without popping: exactly DEPTH pushes, then one pop releases fetch at 64
      do_reset();
      lat_lo = 1; lat_hi = 1;
      repeat (70) cycle();
      chk32("full_pushes", 32'(n_push), 32'd16);
      chk1("full_no_req", mem_req, 1'b0);
      chk1("full_not_empty", IQ_isempty, 1'b0);
      Get_Inst = 1'b1;
      cycle();
      Get_Inst = 1'b0;
      run_until_req(5);
      chk32("after_full_addr", mem_addr, 32'd64);

      // continuous pops with back-to-back refills: head wraps past slot 15
      Get_Inst = 1'b1;
      lat_lo = 0; lat_hi = 0;
      repeat (60) cycle();
      Get_Inst = 1'b0;

      // clear while waiting; stale response arrives 3 cycles later and is dropped
      do_reset();
      lat_lo = 4; lat_hi = 4;
      run_until_req(5);
      cycle();
      clear = 1'b1; clear_pc = 32'h100;
      cycle();
      clear = 1'b0;
      chk1("clr_wait_empty", IQ_isempty, 1'b1);
      chk1("clr_wait_req", mem_req, 1'b0);
      n = 0;
      while (pending && n < 10) begin
         cycle();
         n++;
      end
      chk1("stale_timeout", pending, 1'b0);
      chk1("stale_not_pushed", IQ_isempty, 1'b1);
      cycle();
      chk1("redirect_req", mem_req, 1'b1);
      chk32("redirect_addr", mem_addr, 32'h100);

      // clear together with mem_valid and Get_Inst on a non-empty queue
      do_reset();
      lat_lo = 0; lat_hi = 0;
      repeat (10) cycle();
      n = 0;
      while (!(pending && lat_cnt == 0) && n < 5) begin
         cycle();
         n++;
      end
      chk1("coinc_setup", pending, 1'b1);
      clear = 1'b1; clear_pc = 32'h200; Get_Inst = 1'b1;
      cycle();
      clear = 1'b0; Get_Inst = 1'b0;
      chk1("coinc_empty", IQ_isempty, 1'b1);
      chk1("coinc_req", mem_req, 1'b0);
      cycle();
      chk1("coinc_next_req", mem_req, 1'b1);
      chk32("coinc_next_addr", mem_addr, 32'h200);

      // freeze mid-WAIT holds everything; reset mid-WAIT restarts at RESET_PC
      do_reset();
      lat_lo = 0; lat_hi = 0;
      repeat (8) cycle();
      lat_lo = 3; lat_hi = 3;
      run_until_req(5);
      cycle();
      snap_req = mem_req; snap_addr = mem_addr; snap_empty = IQ_isempty; snap_pc = pc_out;
      rdy_in = 1'b0;
      Get_Inst = 1'b1; clear = 1'b1; clear_pc = 32'h400;
      repeat (5) begin
         cycle();
         chk1("frz_req", mem_req, snap_req);
         chk32("frz_addr", mem_addr, snap_addr);
         chk1("frz_empty", IQ_isempty, snap_empty);
         chk32("frz_pc_out", pc_out, snap_pc);
      end
      rdy_in = 1'b1; Get_Inst = 1'b0; clear = 1'b0;
      cycle();
      chk1("pre_rst_wait", pending && !stale, 1'b1);
      do_reset();
      cycle();
      chk1("post_rst_req", mem_req, 1'b1);
      chk32("post_rst_addr", mem_addr, 32'h0);

      // randomized traffic, alternating pop-heavy and pop-starved stretches
      do_reset();
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         rdy_in   = ($urandom_range(9, 0) != 0);
         Get_Inst = ((i / 500) % 2 == 1) ? ($urandom_range(7, 0) == 0)
                                         : ($urandom_range(2, 0) != 0);
         clear    = ($urandom_range(39, 0) == 0);
         clear_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8
                                                : ($urandom() & 32'hFFFF_FFFC);
         cycle();
      end
      rdy_in = 1'b1; Get_Inst = 1'b0; clear = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
